// File: rtl/mac_fxp_pkg.sv
// Shared types and helpers for the multi-lane fixed-point MAC.
// The clamp helper works on a fixed wide format so it serves any DATA_W up to 64.
package mac_fxp_pkg;

    localparam int SAT_IN_W  = 160;
    localparam int SAT_OUT_W = 64;

    typedef enum logic {
        ROUND_FLOOR   = 1'b0,
        ROUND_HALF_UP = 1'b1
    } round_e;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovf_e;

    typedef struct packed {
        logic [SAT_OUT_W-1:0] data;
        logic                 ovf;
    } sat_res_t;

    function automatic int calc_acc_w(input int dataW, input int guardW);
        return 2 * dataW + guardW;
    endfunction

    // Range-check a sign-extended rescaled sum against a dataW-bit signed result.
    function automatic sat_res_t sat_clamp(input logic signed [SAT_IN_W-1:0] t,
                                           input int                         dataW,
                                           input ovf_e                       mode);
        logic signed [SAT_IN_W-1:0] maxV;
        logic signed [SAT_IN_W-1:0] minV;
        sat_res_t                   res;
        maxV     = (SAT_IN_W'(1) <<< (dataW - 1)) - SAT_IN_W'(1);
        minV     = ~maxV;
        res.ovf  = (t > maxV) || (t < minV);
        res.data = t[SAT_OUT_W-1:0];
        if (res.ovf && mode == OVF_SAT) begin
            res.data = (t > maxV) ? maxV[SAT_OUT_W-1:0] : minV[SAT_OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_fxp_lane.sv
// One MAC lane: pipelined signed multiply, group accumulator, and the
// registered rescale/round/saturate output stage. Control comes from the top.
module mac_fxp_lane
    import mac_fxp_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int GUARD_W     = 8,
    parameter int MULT_CYCLES = 3,
    parameter int ACC_W       = calc_acc_w(DATA_W, GUARD_W),
    parameter int SHIFT_W     = $clog2(ACC_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic                     accEn_i,
    input  logic                     accFirst_i,
    input  logic                     rsEn_i,
    input  logic [SHIFT_W-1:0]       shift_i,
    input  round_e                   round_i,
    input  ovf_e                     ovf_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     sat_o
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_q [MULT_CYCLES];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  prodExt;
    logic signed [ACC_W:0]    accWide;
    logic signed [ACC_W:0]    roundBias;
    logic signed [ACC_W:0]    scaled;
    logic [DATA_W-1:0]        data_q;
    logic [DATA_W-1:0]        data_d;
    logic                     sat_q;
    logic                     sat_d;
    sat_res_t                 clampRes;
    logic                     unusedClampBits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MULT_CYCLES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            prod_q[0] <= PROD_W'(a_i) * PROD_W'(b_i);
            for (int i = 1; i < MULT_CYCLES; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // The first beat of a group loads directly, so no clear cycle is needed.
    always_comb begin
        prodExt = ACC_W'(prod_q[MULT_CYCLES-1]);
        acc_d   = acc_q;
        if (accEn_i) begin
            acc_d = accFirst_i ? prodExt : acc_q + prodExt;
        end
    end

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        accWide   = (ACC_W+1)'(acc_q);
        roundBias = '0;
        if (round_i == ROUND_HALF_UP && shift_i != '0) begin
            roundBias = (ACC_W+1)'(1) <<< (shift_i - SHIFT_W'(1));
        end
        scaled   = (accWide + roundBias) >>> shift_i;
        clampRes = sat_clamp(SAT_IN_W'(scaled), DATA_W, ovf_i);
        data_d   = data_q;
        sat_d    = sat_q;
        if (rsEn_i) begin
            data_d = clampRes.data[DATA_W-1:0];
            sat_d  = clampRes.ovf;
        end
    end

    assign unusedClampBits = ^clampRes.data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            data_q <= data_d;
            sat_q  <= sat_d;
        end
    end

    assign data_o = data_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/mac_fxp_vec.sv
// Multi-lane fixed-point MAC: group tagging, first-beat config capture and the
// control pipe shared by all lanes, which each do multiply/accumulate/rescale.
module mac_fxp_vec
    import mac_fxp_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int GUARD_W     = 8,
    parameter int LANES       = 4,
    parameter int MULT_CYCLES = 3,
    parameter int SHIFT_W     = $clog2(calc_acc_w(DATA_W, GUARD_W))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic [LANES*DATA_W-1:0]   operand_a,
    input  logic [LANES*DATA_W-1:0]   operand_b,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic                      cfg_round,
    input  logic                      cfg_sat,
    output logic                      out_valid,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [LANES-1:0]          out_sat
);

    localparam int ACC_W = calc_acc_w(DATA_W, GUARD_W);

    logic               first_q;
    logic               first_d;
    logic [SHIFT_W-1:0] cfgShift_q;
    logic [SHIFT_W-1:0] cfgShift_d;
    round_e             cfgRound_q;
    round_e             cfgRound_d;
    ovf_e               cfgOvf_q;
    ovf_e               cfgOvf_d;
    logic [SHIFT_W-1:0] beatShift;
    round_e             beatRound;
    ovf_e               beatOvf;

    logic               pipeValid_q [MULT_CYCLES];
    logic               pipeFirst_q [MULT_CYCLES];
    logic               pipeLast_q  [MULT_CYCLES];
    logic [SHIFT_W-1:0] pipeShift_q [MULT_CYCLES];
    round_e             pipeRound_q [MULT_CYCLES];
    ovf_e               pipeOvf_q   [MULT_CYCLES];

    logic               rsEn_q;
    logic [SHIFT_W-1:0] rsShift_q;
    round_e             rsRound_q;
    ovf_e               rsOvf_q;
    logic               outValid_q;

    // Later beats of a group reuse whatever config was present on its first beat.
    always_comb begin
        first_d    = first_q;
        cfgShift_d = cfgShift_q;
        cfgRound_d = cfgRound_q;
        cfgOvf_d   = cfgOvf_q;
        beatShift  = first_q ? cfg_shift          : cfgShift_q;
        beatRound  = first_q ? round_e'(cfg_round) : cfgRound_q;
        beatOvf    = first_q ? ovf_e'(cfg_sat)     : cfgOvf_q;
        if (in_valid) begin
            first_d = in_last;
            if (first_q) begin
                cfgShift_d = cfg_shift;
                cfgRound_d = round_e'(cfg_round);
                cfgOvf_d   = ovf_e'(cfg_sat);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q    <= 1'b1;
            cfgShift_q <= '0;
            cfgRound_q <= ROUND_FLOOR;
            cfgOvf_q   <= OVF_WRAP;
            for (int i = 0; i < MULT_CYCLES; i++) begin
                pipeValid_q[i] <= 1'b0;
                pipeFirst_q[i] <= 1'b0;
                pipeLast_q[i]  <= 1'b0;
                pipeShift_q[i] <= '0;
                pipeRound_q[i] <= ROUND_FLOOR;
                pipeOvf_q[i]   <= OVF_WRAP;
            end
            rsEn_q     <= 1'b0;
            rsShift_q  <= '0;
            rsRound_q  <= ROUND_FLOOR;
            rsOvf_q    <= OVF_WRAP;
            outValid_q <= 1'b0;
        end else begin
            first_q    <= first_d;
            cfgShift_q <= cfgShift_d;
            cfgRound_q <= cfgRound_d;
            cfgOvf_q   <= cfgOvf_d;
            pipeValid_q[0] <= in_valid;
            pipeFirst_q[0] <= first_q;
            pipeLast_q[0]  <= in_last;
            pipeShift_q[0] <= beatShift;
            pipeRound_q[0] <= beatRound;
            pipeOvf_q[0]   <= beatOvf;
            for (int i = 1; i < MULT_CYCLES; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeFirst_q[i] <= pipeFirst_q[i-1];
                pipeLast_q[i]  <= pipeLast_q[i-1];
                pipeShift_q[i] <= pipeShift_q[i-1];
                pipeRound_q[i] <= pipeRound_q[i-1];
                pipeOvf_q[i]   <= pipeOvf_q[i-1];
            end
            rsEn_q     <= pipeValid_q[MULT_CYCLES-1] && pipeLast_q[MULT_CYCLES-1];
            rsShift_q  <= pipeShift_q[MULT_CYCLES-1];
            rsRound_q  <= pipeRound_q[MULT_CYCLES-1];
            rsOvf_q    <= pipeOvf_q[MULT_CYCLES-1];
            outValid_q <= rsEn_q;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : gLane
        mac_fxp_lane #(
            .DATA_W      (DATA_W),
            .GUARD_W     (GUARD_W),
            .MULT_CYCLES (MULT_CYCLES),
            .ACC_W       (ACC_W),
            .SHIFT_W     (SHIFT_W)
        ) uLane (
            .clk        (clk),
            .rst        (rst),
            .a_i        (operand_a[g*DATA_W +: DATA_W]),
            .b_i        (operand_b[g*DATA_W +: DATA_W]),
            .accEn_i    (pipeValid_q[MULT_CYCLES-1]),
            .accFirst_i (pipeFirst_q[MULT_CYCLES-1]),
            .rsEn_i     (rsEn_q),
            .shift_i    (rsShift_q),
            .round_i    (rsRound_q),
            .ovf_i      (rsOvf_q),
            .data_o     (out_data[g*DATA_W +: DATA_W]),
            .sat_o      (out_sat[g])
        );
    end

    assign out_valid = outValid_q;

endmodule

// File: tb/tb_mac_fxp_vec.sv
// Scoreboard bench for mac_fxp_vec: a driver feeds beats and queues the
// expected group results; a monitor pops and compares on every out_valid.
`timescale 1ns/1ps
module tb_mac_fxp_vec;

    localparam int DATA_W      = 16;
    localparam int GUARD_W     = 8;
    localparam int LANES       = 4;
    localparam int MULT_CYCLES = 3;
    localparam int ACC_W       = 2 * DATA_W + GUARD_W;
    localparam int SHIFT_W     = $clog2(ACC_W);
    localparam int VEC_W       = LANES * DATA_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_last;
    logic [VEC_W-1:0]   operand_a;
    logic [VEC_W-1:0]   operand_b;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               cfg_round;
    logic               cfg_sat;
    logic               out_valid;
    logic [VEC_W-1:0]   out_data;
    logic [LANES-1:0]   out_sat;

    mac_fxp_vec #(
        .DATA_W      (DATA_W),
        .GUARD_W     (GUARD_W),
        .LANES       (LANES),
        .MULT_CYCLES (MULT_CYCLES),
        .SHIFT_W     (SHIFT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .cfg_shift (cfg_shift),
        .cfg_round (cfg_round),
        .cfg_sat   (cfg_sat),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VEC_W-1:0] data;
        logic [LANES-1:0] sat;
        longint           cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   monExp;
    int     nChecks = 0;
    int     nFails  = 0;
    longint cyc     = 0;

    // Group-level reference state
    bit     mdlFirst = 1'b1;
    longint mdlSum [LANES];
    int     mdlShift;
    bit     mdlRound;
    bit     mdlSat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Rescale a group sum per the arithmetic definition: wrap, round, shift, range-check.
    function automatic void refLane(input longint s, input int k, input bit rnd, input bit sat,
                                    output logic [DATA_W-1:0] d, output bit ovf);
        longint t;
        longint hi;
        longint lo;
        t = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
        if (rnd && k > 0) t = t + (longint'(1) << (k - 1));
        t  = t >>> k;
        hi = (longint'(1) << (DATA_W - 1)) - 1;
        lo = -hi - 1;
        ovf = (t > hi) || (t < lo);
        if (ovf && sat) t = (t > hi) ? hi : lo;
        d = t[DATA_W-1:0];
    endfunction

    function automatic logic [VEC_W-1:0] randVec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] lane0Vec(input logic [DATA_W-1:0] x);
        logic [VEC_W-1:0] v;
        v = randVec();
        v[DATA_W-1:0] = x;
        return v;
    endfunction

    task automatic applyStimulus(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                                 input bit last, input int shift, input bit rnd, input bit sat);
        exp_t             e;
        longint           p;
        logic [DATA_W-1:0] d;
        bit               ovf;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        in_last   = last;
        cfg_shift = SHIFT_W'(shift);
        cfg_round = rnd;
        cfg_sat   = sat;
        if (mdlFirst) begin
            mdlShift = shift;
            mdlRound = rnd;
            mdlSat   = sat;
        end
        for (int i = 0; i < LANES; i++) begin
            p = longint'($signed(a[i*DATA_W +: DATA_W])) * longint'($signed(b[i*DATA_W +: DATA_W]));
            mdlSum[i] = mdlFirst ? p : mdlSum[i] + p;
        end
        if (last) begin
            for (int i = 0; i < LANES; i++) begin
                refLane(mdlSum[i], mdlShift, mdlRound, mdlSat, d, ovf);
                e.data[i*DATA_W +: DATA_W] = d;
                e.sat[i] = ovf;
            end
            e.cyc = cyc + MULT_CYCLES + 2;
            sb.push_back(e);
        end
        mdlFirst = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() > 0 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                monExp = sb.pop_front();
                for (int i = 0; i < LANES; i++) begin
                    checkOutput($sformatf("lane%0d_data", i),
                                64'(out_data[i*DATA_W +: DATA_W]), 64'(monExp.data[i*DATA_W +: DATA_W]));
                end
                checkOutput("out_sat", 64'(out_sat), 64'(monExp.sat));
                checkOutput("latency_cycle", 64'(cyc), 64'(monExp.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        operand_a = '0;
        operand_b = '0;
        cfg_shift = '0;
        cfg_round = 1'b0;
        cfg_sat   = 1'b0;
        idle(3);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data",  64'(out_data),  64'd0);
        checkOutput("reset_out_sat",   64'(out_sat),   64'd0);
        rst = 1'b0;
        idle(1);

        $display("[TB] basic accumulate");
        for (int j = 0; j < 4; j++) applyStimulus(lane0Vec(16'd3), lane0Vec(16'd4), j == 3, 0, 1'b0, 1'b1);
        drain();

        $display("[TB] q-format rescale");
        applyStimulus(lane0Vec(16'h0180), lane0Vec(16'h0200), 1'b1, 8, 1'b0, 1'b1);
        drain();

        $display("[TB] rounding");
        applyStimulus(lane0Vec(16'd384),  lane0Vec(16'd1), 1'b1, 8, 1'b1, 1'b1);
        applyStimulus(lane0Vec(16'd384),  lane0Vec(16'd1), 1'b1, 8, 1'b0, 1'b1);
        applyStimulus(lane0Vec(16'hFE80), lane0Vec(16'd1), 1'b1, 8, 1'b1, 1'b1);
        applyStimulus(lane0Vec(16'hFE80), lane0Vec(16'd1), 1'b1, 8, 1'b0, 1'b1);
        drain();

        $display("[TB] saturation");
        for (int j = 0; j < 2; j++) applyStimulus(lane0Vec(16'h7FFF), lane0Vec(16'h7FFF), j == 1, 0, 1'b0, 1'b1);
        for (int j = 0; j < 2; j++) applyStimulus(lane0Vec(16'h7FFF), lane0Vec(16'h7FFF), j == 1, 0, 1'b0, 1'b0);
        applyStimulus(lane0Vec(16'h8000), lane0Vec(16'h8000), 1'b1, 0, 1'b0, 1'b1);
        drain();

        $display("[TB] back-to-back, bubbles, config capture");
        applyStimulus(lane0Vec(16'd100), lane0Vec(16'd7), 1'b0, 2, 1'b1, 1'b1);
        idle(3);
        applyStimulus(lane0Vec(16'd50), lane0Vec(16'd9), 1'b1, 5, 1'b0, 1'b0);
        applyStimulus(lane0Vec(16'd1000), lane0Vec(16'd3), 1'b1, 5, 1'b0, 1'b1);
        drain();

        $display("[TB] reset mid-group");
        applyStimulus(randVec(), randVec(), 1'b0, 0, 1'b0, 1'b1);
        applyStimulus(randVec(), randVec(), 1'b0, 0, 1'b0, 1'b1);
        rst = 1'b1;
        mdlFirst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_out_data",  64'(out_data),  64'd0);
        checkOutput("midreset_out_sat",   64'(out_sat),   64'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        applyStimulus(lane0Vec(16'd1), lane0Vec(16'd5), 1'b1, 0, 1'b0, 1'b1);
        drain();

        $display("[TB] randomized groups");
        for (int g = 0; g < 60; g++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                applyStimulus(randVec(), randVec(), j == len - 1, $urandom_range(0, 24),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        drain();

        idle(5);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
